// File: rtl/mem_arbiter.sv
// Main-memory sequencer: arbitrates I/D block fills and write-through stores onto
// one multi-cycle memory port, streaming returned words into the requesting cache.
module mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT       = 4,
  localparam int WORD_W       = $clog2(WORDS_PER_BLK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] fill_data,
  output logic [WORD_W-1:0] fill_word,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              i_busy,
  output logic              d_busy
);
  localparam int WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLK - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_LAT - 2);
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'((2 * WORDS_PER_BLK) - 1);

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

  state_t            state;
  logic [WORD_W-1:0] issue_cnt;
  logic [WORD_W-1:0] recv_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  // A request whose completion pulse is showing is already served, not a new one.
  logic i_want, d_want, w_want, filling;
  assign i_want  = i_miss_req && !i_fill_done;
  assign d_want  = d_miss_req && !d_fill_done;
  assign w_want  = d_wr_req && !d_wr_ack;
  assign filling = (state == FILL_I) || (state == FILL_D);

  assign i_busy    = rst_n && i_want;
  assign d_busy    = rst_n && (d_want || w_want);
  assign fill_we_i = (state == FILL_I) && mem_rvalid;
  assign fill_we_d = (state == FILL_D) && mem_rvalid;
  assign fill_data = (filling && mem_rvalid) ? mem_rdata : '0;
  assign fill_word = filling ? recv_cnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      wait_cnt    <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      d_wr_ack    <= 1'b0;
    end else begin
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      d_wr_ack    <= 1'b0;
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          wait_cnt  <= '0;
          if (w_want) begin
            state     <= WRITE;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= d_wr_addr;
            mem_wdata <= d_wr_data;
          end else if (d_want) begin
            state    <= FILL_D;
            mem_en   <= 1'b1;
            mem_wr   <= 1'b0;
            mem_addr <= d_miss_addr & BLK_MASK;
          end else if (i_want) begin
            state    <= FILL_I;
            mem_en   <= 1'b1;
            mem_wr   <= 1'b0;
            mem_addr <= i_miss_addr & BLK_MASK;
          end
        end
        FILL_I, FILL_D: begin
          if (mem_en) begin
            if (issue_cnt == LAST_WORD) begin
              mem_en <= 1'b0;
            end else begin
              issue_cnt <= issue_cnt + WORD_W'(1);
              mem_addr  <= mem_addr + ADDR_W'(2);
            end
          end
          if (mem_rvalid) begin
            recv_cnt <= recv_cnt + WORD_W'(1);
            if (recv_cnt == LAST_WORD) begin
              state <= IDLE;
              if (state == FILL_I) i_fill_done <= 1'b1;
              else                 d_fill_done <= 1'b1;
            end
          end
        end
        WRITE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          if (d_wr_ack) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == LAST_WAIT) d_wr_ack <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level schedule model predicts
// every output each cycle; a simple latency-queue memory answers the reads.
module tb_mem_arbiter;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int WPB      = 8;
  localparam int MEM_LAT  = 4;
  localparam int FILL_LEN = WPB + MEM_LAT;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_miss_req = 1'b0;
  logic [ADDR_W-1:0] i_miss_addr = '0;
  logic              d_miss_req = 1'b0;
  logic [ADDR_W-1:0] d_miss_addr = '0;
  logic              d_wr_req = 1'b0;
  logic [ADDR_W-1:0] d_wr_addr = '0;
  logic [DATA_W-1:0] d_wr_data = '0;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] fill_data;
  logic [2:0]        fill_word;
  logic              fill_we_i, fill_we_d, i_fill_done, d_fill_done, d_wr_ack, i_busy, d_busy;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_BLK(WPB), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word), .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack),
    .i_busy(i_busy), .d_busy(d_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef enum {OP_NONE, OP_FI, OP_FD, OP_WR} op_t;
  op_t         op = OP_NONE;
  int          op_start = 0;
  logic [15:0] op_addr = '0;
  logic [15:0] op_data = '0;

  int          ret_time[$];
  logic [15:0] ret_data[$];

  bit          rand_mode = 1'b0;
  bit          pend_i = 1'b0, pend_d = 1'b0, pend_w = 1'b0;
  logic [15:0] pend_i_addr, pend_d_addr, pend_w_addr, pend_w_data;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
  endfunction

  task automatic set_i(input logic [15:0] a);
    pend_i = 1'b1; pend_i_addr = a;
  endtask
  task automatic set_d(input logic [15:0] a);
    pend_d = 1'b1; pend_d_addr = a;
  endtask
  task automatic set_w(input logic [15:0] a, input logic [15:0] d);
    pend_w = 1'b1; pend_w_addr = a; pend_w_data = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 32'(mem_en), 0);
    chk({tag, "_wr"}, 32'(mem_wr), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_fdata"}, 32'(fill_data), 0);
    chk({tag, "_fword"}, 32'(fill_word), 0);
    chk({tag, "_we"}, {30'd0, fill_we_i, fill_we_d}, 0);
    chk({tag, "_done"}, {29'd0, i_fill_done, d_fill_done, d_wr_ack}, 0);
    chk({tag, "_busy"}, {30'd0, i_busy, d_busy}, 0);
  endtask

  // One clock cycle: apply requests/memory, compare every output, advance the model.
  task automatic step(input int stray_pct);
    int t;
    bit is_fill, fill_act, e_en, e_wr, e_we, e_idone, e_ddone, e_ack, free;
    int word;
    @(posedge clk);
    #1;
    cyc++;
    t        = cyc - op_start;
    is_fill  = (op == OP_FI) || (op == OP_FD);
    fill_act = is_fill && t >= 0 && t < FILL_LEN;
    e_idone  = (op == OP_FI) && t == FILL_LEN;
    e_ddone  = (op == OP_FD) && t == FILL_LEN;
    e_ack    = (op == OP_WR) && t == MEM_LAT - 1;
    if (e_idone) i_miss_req = 1'b0;
    if (e_ddone) d_miss_req = 1'b0;
    if (e_ack)   d_wr_req   = 1'b0;
    if (pend_i) begin i_miss_req = 1'b1; i_miss_addr = pend_i_addr; pend_i = 1'b0; end
    if (pend_d) begin d_miss_req = 1'b1; d_miss_addr = pend_d_addr; pend_d = 1'b0; end
    if (pend_w) begin
      d_wr_req = 1'b1; d_wr_addr = pend_w_addr; d_wr_data = pend_w_data; pend_w = 1'b0;
    end
    if (rand_mode) begin
      if (!i_miss_req && !e_idone && $urandom_range(0, 7) == 0) begin
        i_miss_req = 1'b1; i_miss_addr = 16'($urandom);
      end
      if (!d_miss_req && !e_ddone && $urandom_range(0, 9) == 0) begin
        d_miss_req = 1'b1; d_miss_addr = 16'($urandom);
      end
      if (!d_wr_req && !e_ack && $urandom_range(0, 9) == 0) begin
        d_wr_req = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
      end
    end
    mem_rvalid = 1'b0;
    if (ret_time.size() > 0 && ret_time[0] == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ret_data[0];
      void'(ret_time.pop_front());
      void'(ret_data.pop_front());
    end else if (!fill_act && ret_time.size() == 0 && $urandom_range(0, 99) < stray_pct) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'($urandom);
    end
    #1;
    e_en = (fill_act && t < WPB) || (op == OP_WR && t == 0);
    e_wr = (op == OP_WR && t == 0);
    chk("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) begin
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("mem_addr", 32'(mem_addr), e_wr ? 32'(op_addr) : 32'(16'(op_addr + 2 * t)));
    end
    if (e_wr) chk("mem_wdata", 32'(mem_wdata), 32'(op_data));
    e_we = fill_act && t >= MEM_LAT;
    chk("fill_we_i", 32'(fill_we_i), 32'(e_we && op == OP_FI));
    chk("fill_we_d", 32'(fill_we_d), 32'(e_we && op == OP_FD));
    if (e_we) begin
      word = t - MEM_LAT;
      chk("fill_word", 32'(fill_word), 32'(word));
      chk("fill_data", 32'(fill_data), 32'(mem_word(16'(op_addr + 2 * word))));
    end
    chk("i_fill_done", 32'(i_fill_done), 32'(e_idone));
    chk("d_fill_done", 32'(d_fill_done), 32'(e_ddone));
    chk("d_wr_ack", 32'(d_wr_ack), 32'(e_ack));
    chk("i_busy", 32'(i_busy), 32'(i_miss_req && !e_idone));
    chk("d_busy", 32'(d_busy), 32'((d_miss_req && !e_ddone) || (d_wr_req && !e_ack)));
    if (mem_en && !mem_wr) begin
      ret_time.push_back(cyc + MEM_LAT);
      ret_data.push_back(mem_word(mem_addr));
    end
    free = (op == OP_NONE) || (is_fill && t >= FILL_LEN) || (op == OP_WR && t >= MEM_LAT);
    if (free) begin
      op = OP_NONE;
      if (d_wr_req) begin
        op = OP_WR; op_addr = d_wr_addr; op_data = d_wr_data;
      end else if (d_miss_req) begin
        op = OP_FD; op_addr = d_miss_addr & 16'hFFF0;
      end else if (i_miss_req) begin
        op = OP_FI; op_addr = i_miss_addr & 16'hFFF0;
      end
      op_start = cyc + 1;
    end
  endtask

  task automatic run(input int n, input int stray_pct);
    for (int k = 0; k < n; k++) step(stray_pct);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    run(2, 0);

    set_i(16'h0126);
    run(16, 0);

    set_i(16'h0040);
    set_d(16'h2008);
    run(30, 0);

    set_w(16'h3002, 16'hBEEF);
    set_d(16'h3100);
    run(22, 0);

    set_i(16'h0200);
    for (int n = 0; n < 40 && !(op == OP_FI && cyc - op_start == MEM_LAT + 3); n++) step(0);
    set_w(16'h4444, 16'h1234);
    run(24, 0);

    set_i(16'h0500);
    for (int n = 0; n < 40 && !(op == OP_FI && cyc - op_start == MEM_LAT + 5); n++) step(0);
    rst_n = 1'b0;
    i_miss_req = 1'b0;
    #1;
    chk_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (k == 1) rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 16'($urandom);
      #1;
      chk("post_rst_we", {30'd0, fill_we_i, fill_we_d}, 0);
      chk("post_rst_en", 32'(mem_en), 0);
      chk("post_rst_done", {29'd0, i_fill_done, d_fill_done, d_wr_ack}, 0);
    end
    mem_rvalid = 1'b0;
    op = OP_NONE;
    ret_time.delete();
    ret_data.delete();
    run(2, 0);

    set_d(16'hFFFA);
    run(16, 0);

    run(10, 100);

    rand_mode = 1'b1;
    run(3000, 15);
    rand_mode = 1'b0;
    run(80, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-ported, multi-cycle unified main memory for the pipelined CPU.
- Arbitrates between three requesters:
  - I-cache block fills (fetch-stage misses).
  - D-cache block fills (memory-stage misses).
  - D-side write-through stores.
- Issues pipelined word reads for each block fill and streams the returned words into the requesting cache.
- Drives per-requester busy signals that the hazard detection unit turns into PC/IF_ID and EX_MEM stalls.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, memory word width.
- WORDS_PER_BLK, 8, words per cache block (power of 2).
- MEM_LAT, 4, cycles from read issue to mem_rvalid. Also the fixed duration of a write.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_miss_req  in  1  I-cache miss. Level, held until i_fill_done.
- i_miss_addr  in  ADDR_W  I-side miss byte address.
- d_miss_req  in  1  D-cache miss. Level, held until d_fill_done.
- d_miss_addr  in  ADDR_W  D-side miss byte address.
- d_wr_req  in  1  store request. Level, held until d_wr_ack.
- d_wr_addr  in  ADDR_W  store byte address.
- d_wr_data  in  DATA_W  store data.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  1 = write, 0 = read. Valid only with mem_en.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_rvalid  in  1  mem_rdata valid.
- fill_data  out  DATA_W  word being written into a cache.
- fill_word  out  log2(WORDS_PER_BLK)  word index within the block.
- fill_we_i  out  1  write fill_data into the I-cache.
- fill_we_d  out  1  write fill_data into the D-cache.
- i_fill_done  out  1  one-cycle pulse: I block complete.
- d_fill_done  out  1  one-cycle pulse: D block complete.
- d_wr_ack  out  1  one-cycle pulse: store complete.
- i_busy  out  1  I-side request pending or in service.
- d_busy  out  1  D-side request (miss or store) pending or in service.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = IDLE; all counters = 0.
  - All outputs 0; fill_data = 0.
- States:
  - IDLE, FILL_I, FILL_D, WRITE.
- Arbitration in IDLE:
  - Fixed priority d_wr_req > d_miss_req > i_miss_req. The memory stage is the older instruction.
  - Exactly one grant per cycle; the grant takes effect on the next edge.
  - No preemption: a granted operation runs to completion.
  - Losing requests stay pending and their busy stays high.
- Busy signals:
  - i_busy = i_miss_req & ~i_fill_done.
  - d_busy = (d_miss_req & ~d_fill_done) | (d_wr_req & ~d_wr_ack).
  - Both are combinational.
- FILL_x (block fill):
  - Block base = miss_addr with the low log2(2*WORDS_PER_BLK) bits cleared. Latched at grant.
  - Issue counter k runs 0..WORDS_PER_BLK-1. One read per cycle: mem_en=1, mem_wr=0, mem_addr = base + 2k.
  - After the last read is issued, mem_en = 0.
  - Receive counter r increments on each mem_rvalid.
  - Per received word: fill_data = mem_rdata, fill_word = r, fill_we_x = 1. All combinational with mem_rvalid.
  - When r reaches WORDS_PER_BLK-1 and mem_rvalid is high: pulse x_fill_done on the next cycle, then return to IDLE.
  - Total fill latency from grant edge to done pulse = WORDS_PER_BLK + MEM_LAT cycles (12 with defaults).
- WRITE (store):
  - On entry: mem_en=1, mem_wr=1, mem_addr = d_wr_addr, mem_wdata = d_wr_data, for one cycle.
  - Then wait MEM_LAT-1 cycles using the wait counter.
  - d_wr_ack pulses in the final cycle; next state is IDLE.
- Stray returns: mem_rvalid outside FILL_x is ignored. No fill_we, no counter change.
- Back-to-back requests:
  - A request still asserted in the cycle after its done/ack pulse is a new request.
  - The requester must drop the request in the pulse cycle.
- Reset mid-operation:
  - Immediate abort; all outputs return to reset values.
  - In-flight memory returns after reset are ignored (state is IDLE).
- Address arithmetic: mem_addr wraps modulo 2^ADDR_W. A base at 0xFFF0 issues 0xFFF0..0xFFFE.

Test Plan:
- i_miss_req=1 with i_miss_addr=0x0126, idle memory:
  - Reads issued at 0x0120, 0x0122, …, 0x012E on 8 consecutive cycles.
  - fill_we_i with fill_word 0..7.
  - i_fill_done 12 cycles after the grant edge; d-side outputs stay 0.
- i_miss_req and d_miss_req rise in the same cycle (addresses 0x0040 and 0x2008):
  - D fill at 0x2000..0x200E completes first; i_busy stays 1 throughout.
  - I fill at 0x0040 starts the cycle after IDLE is re-entered.
- d_wr_req (0x3002, 0xBEEF) and d_miss_req asserted together:
  - Write issued first: mem_wr=1, mem_addr=0x3002, mem_wdata=0xBEEF.
  - d_wr_ack after 4 cycles, then the D fill proceeds.
- d_wr_req asserted mid I-fill (word 3):
  - I fill is not preempted.
  - Write issued after i_fill_done; d_busy=1 until d_wr_ack.
- rst_n dropped at fill_word=5, mem_rvalid still pulsing for 3 more cycles:
  - All outputs are 0 immediately.
  - No fill_we_* after reset; state is IDLE when rst_n rises.
- Miss at 0xFFFA:
  - Reads issued at 0xFFF0..0xFFFE; no address wraps past 0xFFFE.
- mem_rvalid pulsed while in IDLE:
  - No fill_we_* and no done pulses.
